// File: rtl/irrigation_sequencer_pkg.sv
// Shared types for the irrigation sequencer: FSM state codes and actuator mode.
package irrigacao_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_RUN      = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  typedef enum logic {
    MODE_SPRINKLE = 1'b0,
    MODE_DRIP     = 1'b1
  } mode_e;

endpackage

// File: rtl/irrigation_sequencer_if.sv
// Request/actuator bundle between the decision logic and the sequencer.
interface irrigation_sequencer_if;

  logic       bs_req;
  logic       vs_req;
  logic       err;
  logic       nv_baixo;
  logic       manual_stop;
  logic       fault_clr;
  logic       pump_on;
  logic       valve_on;
  logic       busy;
  logic       fault;
  logic [2:0] state;

  modport master (
    output bs_req, vs_req, err, nv_baixo, manual_stop, fault_clr,
    input  pump_on, valve_on, busy, fault, state
  );

  modport slave (
    input  bs_req, vs_req, err, nv_baixo, manual_stop, fault_clr,
    output pump_on, valve_on, busy, fault, state
  );

endinterface

// File: rtl/irrigation_sequencer_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
module tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/irrigation_sequencer.sv
// Sequences sprinkler/drip runs: debounce, min/max run time, cooldown and latched fault.
module irrigation_sequencer #(
  parameter int TICK_DIV   = 1000,
  parameter int DEB_TICKS  = 4,
  parameter int MIN_ON     = 10,
  parameter int MAX_ON     = 60,
  parameter int COOL_TICKS = 20,
  parameter int CW         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  irrigation_sequencer_if.slave  bus
);

  import irrigacao_pkg::*;

  localparam logic [CW-1:0] DEB_C  = CW'(DEB_TICKS);
  localparam logic [CW-1:0] MIN_C  = CW'(MIN_ON);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_ON);
  localparam logic [CW-1:0] COOL_C = CW'(COOL_TICKS);

  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic          w_tick;
  state_e        r_state;
  mode_e         r_mode;
  logic [CW-1:0] r_deb_cnt;
  logic [CW-1:0] r_run_cnt;
  logic [CW-1:0] r_cool_cnt;
  logic          r_pump_on;
  logic          r_valve_on;
  logic          r_busy;
  logic          r_fault;

  state_e        w_next_state;
  mode_e         w_next_mode;
  logic [CW-1:0] w_next_deb;
  logic [CW-1:0] w_next_run;
  logic [CW-1:0] w_next_cool;
  logic          w_latched_req;
  logic [CW-1:0] w_deb_inc;
  logic [CW-1:0] w_run_inc;
  logic [CW-1:0] w_cool_inc;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_latched_req = (r_mode == MODE_SPRINKLE) ? bus.bs_req : bus.vs_req;
  assign w_deb_inc     = satInc(r_deb_cnt);
  assign w_run_inc     = satInc(r_run_cnt);
  assign w_cool_inc    = satInc(r_cool_cnt);

  // err pre-empts everything; water loss / operator stop end a run without waiting for a tick
  always_comb begin
    w_next_state = r_state;
    w_next_mode  = r_mode;
    w_next_deb   = r_deb_cnt;
    w_next_run   = r_run_cnt;
    w_next_cool  = r_cool_cnt;
    if (bus.err && (r_state != ST_FAULT)) begin
      w_next_state = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_tick && (bus.bs_req || bus.vs_req)) begin
            w_next_mode  = bus.bs_req ? MODE_SPRINKLE : MODE_DRIP;
            w_next_deb   = '0;
            w_next_state = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (w_tick) begin
            if (!w_latched_req) begin
              w_next_state = ST_IDLE;
            end else begin
              w_next_deb = w_deb_inc;
              if (w_deb_inc >= DEB_C) begin
                if (bus.nv_baixo && !bus.manual_stop) begin
                  w_next_run   = '0;
                  w_next_state = ST_RUN;
                end else begin
                  w_next_state = ST_IDLE;
                end
              end
            end
          end
        end
        ST_RUN: begin
          if (!bus.nv_baixo || bus.manual_stop) begin
            w_next_cool  = '0;
            w_next_state = ST_COOLDOWN;
          end else if (w_tick) begin
            w_next_run = w_run_inc;
            if ((w_run_inc >= MAX_C) || ((w_run_inc >= MIN_C) && !w_latched_req)) begin
              w_next_cool  = '0;
              w_next_state = ST_COOLDOWN;
            end
          end
        end
        ST_COOLDOWN: begin
          if (w_tick) begin
            w_next_cool = w_cool_inc;
            if (w_cool_inc >= COOL_C) begin
              w_next_state = ST_IDLE;
            end
          end
        end
        ST_FAULT: begin
          if (bus.fault_clr && !bus.err) begin
            w_next_state = ST_IDLE;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_SPRINKLE;
      r_deb_cnt  <= '0;
      r_run_cnt  <= '0;
      r_cool_cnt <= '0;
      r_pump_on  <= 1'b0;
      r_valve_on <= 1'b0;
      r_busy     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_mode     <= w_next_mode;
      r_deb_cnt  <= w_next_deb;
      r_run_cnt  <= w_next_run;
      r_cool_cnt <= w_next_cool;
      r_pump_on  <= (w_next_state == ST_RUN) && (w_next_mode == MODE_SPRINKLE);
      r_valve_on <= (w_next_state == ST_RUN) && (w_next_mode == MODE_DRIP);
      r_busy     <= (w_next_state != ST_IDLE);
      r_fault    <= (w_next_state == ST_FAULT);
    end
  end

  assign bus.pump_on  = r_pump_on;
  assign bus.valve_on = r_valve_on;
  assign bus.busy     = r_busy;
  assign bus.fault    = r_fault;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed plus randomized bench for irrigation_sequencer against a tick-level behavioural model.
module tb_irrigation_sequencer;

  localparam int TD   = 4;
  localparam int DEB  = 2;
  localparam int MINR = 3;
  localparam int MAXR = 6;
  localparam int COOL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  irrigation_sequencer_if bus ();

  irrigation_sequencer #(
    .TICK_DIV   (TD),
    .DEB_TICKS  (DEB),
    .MIN_ON     (MINR),
    .MAX_ON     (MAXR),
    .COOL_TICKS (COOL),
    .CW         (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: phase uses the published state codes; counts are ticks spent in the current phase
  int cyc;
  int mPhase;
  bit mSprinkle;
  int mHeld;
  int mRun;
  int mCool;

  task automatic modelReset();
    cyc = 0; mPhase = 0; mSprinkle = 1'b1; mHeld = 0; mRun = 0; mCool = 0;
  endtask

  task automatic modelStep();
    bit isTick;
    bit req;
    isTick = ((cyc % TD) == TD - 1);
    cyc++;
    req = mSprinkle ? bus.bs_req : bus.vs_req;
    if (bus.err && mPhase != 4) begin
      mPhase = 4;
    end else if (mPhase == 0) begin
      if (isTick && (bus.bs_req || bus.vs_req)) begin
        mSprinkle = bus.bs_req; mHeld = 0; mPhase = 1;
      end
    end else if (mPhase == 1) begin
      if (isTick) begin
        if (!req) mPhase = 0;
        else begin
          mHeld++;
          if (mHeld >= DEB) begin
            if (bus.nv_baixo && !bus.manual_stop) begin mPhase = 2; mRun = 0; end
            else mPhase = 0;
          end
        end
      end
    end else if (mPhase == 2) begin
      if (!bus.nv_baixo || bus.manual_stop) begin
        mPhase = 3; mCool = 0;
      end else if (isTick) begin
        mRun++;
        if (mRun >= MAXR || (mRun >= MINR && !req)) begin mPhase = 3; mCool = 0; end
      end
    end else if (mPhase == 3) begin
      if (isTick) begin
        mCool++;
        if (mCool >= COOL) mPhase = 0;
      end
    end else begin
      if (bus.fault_clr && !bus.err) mPhase = 0;
    end
  endtask

  task automatic compareVal(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic checkOutput();
    compareVal("pump_on", {2'b0, bus.pump_on}, {2'b0, (mPhase == 2 && mSprinkle)});
    compareVal("valve_on", {2'b0, bus.valve_on}, {2'b0, (mPhase == 2 && !mSprinkle)});
    compareVal("busy", {2'b0, bus.busy}, {2'b0, (mPhase != 0)});
    compareVal("fault", {2'b0, bus.fault}, {2'b0, (mPhase == 4)});
    compareVal("state", bus.state, 3'(mPhase));
    compareVal("exclusive", {2'b0, bus.pump_on & bus.valve_on}, 3'd0);
  endtask

  task automatic applyStimulus(input bit bs, input bit vs, input bit er,
                               input bit nv, input bit ms, input bit clr);
    bus.bs_req = bs; bus.vs_req = vs; bus.err = er;
    bus.nv_baixo = nv; bus.manual_stop = ms; bus.fault_clr = clr;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      modelStep();
      @(posedge clk);
      #1;
      checkOutput();
    end
  endtask

  task automatic runUntil(input int phase, input int budget);
    int left;
    left = budget;
    while (mPhase != phase && left > 0) begin
      runCycles(1);
      left--;
    end
    if (mPhase != phase) begin
      failures++;
      $display("[TB] FAIL wait_phase observed=%0d expected=%0d", mPhase, phase);
    end
  endtask

  task automatic runUntilRunTicks(input int n, input int budget);
    int left;
    left = budget;
    while (!(mPhase == 2 && mRun == n) && left > 0) begin
      runCycles(1);
      left--;
    end
    if (!(mPhase == 2 && mRun == n)) begin
      failures++;
      $display("[TB] FAIL wait_run observed=%0d expected=%0d", mRun, n);
    end
  endtask

  initial begin
    modelReset();
    applyStimulus(0, 0, 0, 1, 0, 0);
    #1;
    compareVal("reset_state", bus.state, 3'd0);
    compareVal("reset_outs", {bus.pump_on, bus.valve_on, bus.busy | bus.fault}, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();

    $display("[TB] normal sprinkler run");
    applyStimulus(1, 0, 0, 1, 0, 0);
    runUntil(2, 60);
    compareVal("sprinkle_run_cycle", 3'(cyc), 3'(3 * TD));
    runUntilRunTicks(4, 60);
    applyStimulus(0, 0, 0, 1, 0, 0);
    runUntil(3, 20);
    runUntil(0, 40);

    $display("[TB] debounce reject");
    applyStimulus(0, 1, 0, 1, 0, 0);
    runUntil(1, 20);
    applyStimulus(0, 0, 0, 1, 0, 0);
    runUntil(0, 20);
    runCycles(2 * TD);

    $display("[TB] min and max run");
    applyStimulus(0, 1, 0, 1, 0, 0);
    runUntil(2, 60);
    runUntilRunTicks(1, 20);
    applyStimulus(0, 0, 0, 1, 0, 0);
    runUntil(3, 40);
    runUntil(0, 40);
    applyStimulus(0, 1, 0, 1, 0, 0);
    runUntil(2, 60);
    runUntil(3, 60);
    applyStimulus(0, 0, 0, 1, 0, 0);
    runUntil(0, 40);

    $display("[TB] water loss mid-run");
    applyStimulus(1, 0, 0, 1, 0, 0);
    runUntil(2, 60);
    runCycles(TD + 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    runCycles(1);
    compareVal("waterloss_state", bus.state, 3'd3);
    applyStimulus(0, 0, 0, 1, 0, 0);
    runUntil(0, 40);

    $display("[TB] fault latch");
    applyStimulus(1, 0, 0, 1, 0, 0);
    runUntil(2, 60);
    applyStimulus(1, 0, 1, 1, 0, 0);
    runCycles(1);
    compareVal("fault_state", bus.state, 3'd4);
    applyStimulus(1, 0, 1, 1, 0, 1);
    runCycles(1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    runCycles(3);
    applyStimulus(0, 0, 0, 1, 0, 1);
    runCycles(1);
    compareVal("fault_cleared", bus.state, 3'd0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    runCycles(2);

    $display("[TB] simultaneous requests and async reset");
    applyStimulus(1, 1, 0, 1, 0, 0);
    runUntil(2, 60);
    runCycles(3);
    rst_n = 1'b0;
    #1;
    compareVal("async_rst_pump", {2'b0, bus.pump_on}, 3'd0);
    compareVal("async_rst_state", bus.state, 3'd0);
    modelReset();
    applyStimulus(0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();

    $display("[TB] randomized sequence");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 11) == 0) ? !bus.bs_req : bus.bs_req,
                    ($urandom_range(0, 11) == 0) ? !bus.vs_req : bus.vs_req,
                    ($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 29) != 0),
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 5) == 0));
      runCycles(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
